traffic_interval_timer: RTL and testbench

- Interval timer for the traffic_system controller. It consumes the controller's start-timer strobe ST and produces the short-interval flag TS and long-interval flag TL that gate the light FSM.
- A prescaler divides clk into timer ticks. A saturating tick counter is compared against the short and long thresholds.
- The block sits beside the controller in the same clock domain, with ST in and TS/TL out.

---
 rtl/traffic_interval_timer.sv | 72 +++++++
 tb/tb_traffic_interval_timer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/traffic_interval_timer.sv
// Interval timer beside the traffic controller: prescaled, saturating tick counter with short/long flags.
// Optional build macro TIMER_FREEZE_EN adds a HOLD input that freezes counting while asserted.
module traffic_interval_timer #(
  parameter int PRESCALE    = 1,
  parameter int SHORT_TICKS = 2,
  parameter int LONG_TICKS  = 5,
  parameter int CNT_W       = $clog2(LONG_TICKS + 1),
  parameter int PRE_W       = ($clog2(PRESCALE) > 0) ? $clog2(PRESCALE) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ST,
`ifdef TIMER_FREEZE_EN
  input  logic HOLD,
`endif
  output logic TS,
  output logic TL,
  output logic EXP,
  output logic dbg_state
);

  typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(SHORT_TICKS);
  localparam logic [CNT_W-1:0] CNT_LONG  = CNT_W'(LONG_TICKS);

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] cnt;
  logic             frozen;

`ifdef TIMER_FREEZE_EN
  assign frozen = HOLD;
`else
  assign frozen = 1'b0;
`endif

  // Restart outranks freeze, which outranks counting; DONE holds pre/cnt so nothing wraps.
  always_ff @(posedge clk) begin
    if (rst || ST) begin
      pre   <= '0;
      cnt   <= '0;
      state <= RUN;
      EXP   <= 1'b0;
    end else if (frozen) begin
      EXP <= 1'b0;
    end else if (state == RUN) begin
      if (pre == PRE_MAX) begin
        pre <= '0;
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state <= DONE;
          EXP   <= 1'b1;
        end else begin
          EXP <= 1'b0;
        end
      end else begin
        pre <= pre + 1'b1;
        EXP <= 1'b0;
      end
    end else begin
      EXP <= 1'b0;
    end
  end

  assign TS        = (cnt >= CNT_SHORT);
  assign TL        = (cnt >= CNT_LONG);
  assign dbg_state = state;

endmodule

// File: tb/tb_traffic_interval_timer.sv
// Randomized bench for traffic_interval_timer: two configurations checked against an elapsed-cycle model.
module tb_traffic_interval_timer;

  logic clk = 1'b0;
  logic rst, st, hold;
  logic ts_a, tl_a, exp_a, dbg_a;
  logic ts_b, tl_b, exp_b, dbg_b;

  int total = 0;
  int bad   = 0;

  // Model: cycles elapsed since the last restart, saturating at LONG*PRESCALE.
  int prs [2] = '{1, 3};
  int shrt[2] = '{2, 2};
  int lng [2] = '{5, 4};
  int el  [2];
  bit ex  [2];

  always #5 clk = ~clk;

  traffic_interval_timer dut_a (
    .clk(clk), .rst(rst), .ST(st),
`ifdef TIMER_FREEZE_EN
    .HOLD(hold),
`endif
    .TS(ts_a), .TL(tl_a), .EXP(exp_a), .dbg_state(dbg_a)
  );

  traffic_interval_timer #(.PRESCALE(3), .SHORT_TICKS(2), .LONG_TICKS(4)) dut_b (
    .clk(clk), .rst(rst), .ST(st),
`ifdef TIMER_FREEZE_EN
    .HOLD(hold),
`endif
    .TS(ts_b), .TL(tl_b), .EXP(exp_b), .dbg_state(dbg_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst || st) begin
        el[k] = 0;
        ex[k] = 1'b0;
      end else if (hold) begin
        ex[k] = 1'b0;
      end else if (el[k] < lng[k] * prs[k]) begin
        el[k]++;
        ex[k] = (el[k] == lng[k] * prs[k]);
      end else begin
        ex[k] = 1'b0;
      end
    end
    #1;
    begin
      int ca, cb;
      ca = el[0] / prs[0];
      cb = el[1] / prs[1];
      check("a_cnt", 32'(dut_a.cnt), ca);
      check("a_ts", ts_a, ca >= shrt[0]);
      check("a_tl", tl_a, ca >= lng[0]);
      check("a_exp", exp_a, ex[0]);
      check("a_state", dbg_a, ca >= lng[0]);
      check("b_cnt", 32'(dut_b.cnt), cb);
      check("b_ts", ts_b, cb >= shrt[1]);
      check("b_tl", tl_b, cb >= lng[1]);
      check("b_exp", exp_b, ex[1]);
      check("b_state", dbg_b, cb >= lng[1]);
    end
  endtask

  initial begin
    el[0] = 0; el[1] = 0; ex[0] = 1'b0; ex[1] = 1'b0;
    rst = 1'b1; st = 1'b0; hold = 1'b0;
    repeat (2) step();

    // Free run from reset release, no ST needed.
    rst = 1'b0;
    repeat (30) step();

    // Single-cycle ST pulse while TL is high.
    st = 1'b1; step();
    st = 1'b0; repeat (15) step();

    // ST held for 10 cycles.
    st = 1'b1; repeat (10) step();
    st = 1'b0; repeat (15) step();

    // Reset two cycles into a count, with ST concurrent.
    st = 1'b1; step();
    st = 1'b0; repeat (2) step();
    rst = 1'b1; st = 1'b1; step();
    rst = 1'b0; st = 1'b0; repeat (20) step();

`ifdef TIMER_FREEZE_EN
    // Freeze at cnt=3 of the default instance for 7 cycles.
    st = 1'b1; step();
    st = 1'b0; repeat (3) step();
    hold = 1'b1; repeat (7) step();
    hold = 1'b0; repeat (10) step();
`endif

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      st  = ($urandom_range(0, 15) == 0);
`ifdef TIMER_FREEZE_EN
      hold = ($urandom_range(0, 5) == 0);
`endif
      step();
    end

    rst = 1'b0; st = 1'b0; hold = 1'b0;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
